// File: rtl/dff_chk_pkg.sv
// Shared definitions for the counter checker: state encodings and default sizes.
package dff_chk_pkg;

   // State encoding; 2'd3 is never entered and is treated as IDLE.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEEK   = 2'd1,
      ST_LOCKED = 2'd2,
      ST_RSVD   = 2'd3
   } chk_state_e;

   localparam int DEF_WIDTH      = 4;
   localparam int DEF_ERR_W      = 8;
   localparam int DEF_LOCK_COUNT = 4;
   // Match counter width: wide enough for LOCK_COUNT up to 15.
   localparam int MATCH_W        = 4;

endpackage : dff_chk_pkg

// File: rtl/dff_count_checker_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count for the current value, held once the all-ones ceiling is reached.
   function automatic logic [W-1:0] sat_next(input logic [W-1:0] cur);
      logic [W-1:0] res;
      if (cur == {W{1'b1}}) begin
         res = cur;
      end else begin
         res = cur + {{(W-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

   // Next-count selection.
   always_comb begin
      count_d = count_q;
      if (inc) begin
         count_d = sat_next(count_q);
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : sat_counter

// File: rtl/dff_count_checker.sv
// Monitor for a free-running counter's q/qnot pair: checks complement integrity,
// checks +1 sequencing once locked, and counts error events.
module dff_count_checker
   import dff_chk_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int ERR_W      = DEF_ERR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] qnot,
   output logic             locked,
   output logic             compl_err,
   output logic             seq_err,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] expected
);

   localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_COUNT);

   chk_state_e         state_q,     state_d;
   logic [WIDTH-1:0]   last_q,      last_d;
   logic [WIDTH-1:0]   expected_q,  expected_d;
   logic [MATCH_W-1:0] match_q,     match_d;
   logic               locked_q,    locked_d;
   logic               compl_err_q, compl_err_d;
   logic               seq_err_q,   seq_err_d;
   logic               err_inc_s;
   logic               clean_s;
   logic               in_seq_s;
   logic [WIDTH-1:0]   q_next_s;
   logic [MATCH_W-1:0] match_inc_s;

   assign clean_s     = (qnot == ~q);
   assign in_seq_s    = (q == expected_q);
   assign q_next_s    = q + {{(WIDTH-1){1'b0}}, 1'b1};
   assign match_inc_s = match_q + {{(MATCH_W-1){1'b0}}, 1'b1};

   // FSM next state, prediction update, flag pulses and error-count request.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      expected_d  = expected_q;
      match_d     = match_q;
      compl_err_d = 1'b0;
      seq_err_d   = 1'b0;
      err_inc_s   = 1'b0;
      if (en) begin
         case (state_q)
            ST_SEEK: begin
               if (!clean_s) begin
                  compl_err_d = 1'b1;
                  err_inc_s   = 1'b1;
                  match_d     = {MATCH_W{1'b0}};
                  state_d     = ST_IDLE;
               end else if (in_seq_s) begin
                  last_d     = q;
                  expected_d = q_next_s;
                  match_d    = match_inc_s;
                  if (match_inc_s == LOCK_TARGET) begin
                     state_d = ST_LOCKED;
                  end else begin
                     state_d = ST_SEEK;
                  end
               end else begin
                  // Out-of-sequence before lock only restarts the run; no flag.
                  last_d     = q;
                  expected_d = q_next_s;
                  match_d    = {MATCH_W{1'b0}};
                  state_d    = ST_SEEK;
               end
            end
            ST_LOCKED: begin
               compl_err_d = !clean_s;
               seq_err_d   = !in_seq_s;
               last_d      = q;
               expected_d  = q_next_s;
               if (clean_s && in_seq_s) begin
                  state_d = ST_LOCKED;
               end else begin
                  // One event per sample even when both checks fail.
                  err_inc_s = 1'b1;
                  match_d   = {MATCH_W{1'b0}};
                  if (clean_s) begin
                     state_d = ST_SEEK;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: begin
               // IDLE, and the unreachable encoding which decodes as IDLE.
               if (clean_s) begin
                  last_d     = q;
                  expected_d = q_next_s;
                  match_d    = {MATCH_W{1'b0}};
                  state_d    = ST_SEEK;
               end else begin
                  compl_err_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
         endcase
      end else begin
         state_d = state_q;
      end
      locked_d = (state_d == ST_LOCKED);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         last_q      <= {WIDTH{1'b0}};
         expected_q  <= {WIDTH{1'b0}};
         match_q     <= {MATCH_W{1'b0}};
         locked_q    <= 1'b0;
         compl_err_q <= 1'b0;
         seq_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         expected_q  <= expected_d;
         match_q     <= match_d;
         locked_q    <= locked_d;
         compl_err_q <= compl_err_d;
         seq_err_q   <= seq_err_d;
      end
   end

   sat_counter #(
      .W (ERR_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (err_inc_s),
      .count (err_count)
   );

   assign locked    = locked_q;
   assign compl_err = compl_err_q;
   assign seq_err   = seq_err_q;
   assign expected  = expected_q;

endmodule : dff_count_checker

// File: tb/tb_dff_count_checker.sv
// Scoreboard bench for dff_count_checker: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares against both instances.
module tb_dff_count_checker;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] q;
   logic [3:0] qnot;

   logic       locked,    locked_s2;
   logic       compl_err, compl_err_s2;
   logic       seq_err,   seq_err_s2;
   logic [7:0] err_count;
   logic [1:0] err_count_s2;
   logic [3:0] expected,  expected_s2;

   typedef struct packed {
      logic       lk;
      logic       ce;
      logic       se;
      logic [7:0] ec;
      logic [3:0] ex;
      logic [1:0] es;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   dff_count_checker #(.WIDTH(4), .LOCK_COUNT(4), .ERR_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .q         (q),
      .qnot      (qnot),
      .locked    (locked),
      .compl_err (compl_err),
      .seq_err   (seq_err),
      .err_count (err_count),
      .expected  (expected)
   );

   // Second instance with a 2-bit error counter for the saturation checks.
   dff_count_checker #(.WIDTH(4), .LOCK_COUNT(4), .ERR_W(2)) u_dut_sat (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .q         (q),
      .qnot      (qnot),
      .locked    (locked_s2),
      .compl_err (compl_err_s2),
      .seq_err   (seq_err_s2),
      .err_count (err_count_s2),
      .expected  (expected_s2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   // Monitor: compares outputs against the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("locked",       int'(locked),       int'(e.lk));
         chk("compl_err",    int'(compl_err),    int'(e.ce));
         chk("seq_err",      int'(seq_err),      int'(e.se));
         chk("err_count",    int'(err_count),    int'(e.ec));
         chk("expected",     int'(expected),     int'(e.ex));
         chk("err_count_w2", int'(err_count_s2), int'(e.es));
      end
   end

   task automatic step(input logic r, input logic e, input logic [3:0] vq,
                       input logic [3:0] vqn, input logic lk, input logic ce,
                       input logic se, input logic [7:0] ec, input logic [3:0] ex,
                       input logic [1:0] es);
      exp_t x;
      @(negedge clk);
      rst  = r;
      en   = e;
      q    = vq;
      qnot = vqn;
      @(posedge clk);
      x.lk = lk; x.ce = ce; x.se = se; x.ec = ec; x.ex = ex; x.es = es;
      exp_q.push_back(x);
   endtask

   // Clean sample with en high.
   task automatic stepc(input logic [3:0] vq, input logic lk, input logic [7:0] ec,
                        input logic [3:0] ex, input logic [1:0] es);
      step(1'b1, 1'b1, vq, ~vq, lk, 1'b0, 1'b0, ec, ex, es);
   endtask

   initial begin
      int wait_cnt;
      rst  = 1'b0;
      en   = 1'b0;
      q    = 4'd0;
      qnot = 4'd15;

      // Reset for two edges.
      step(1'b0, 1'b0, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 2'd0);
      step(1'b0, 1'b0, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 2'd0);

      // Clean free-running counter: lock after sample 4, then wrap 15->0.
      stepc(4'd0, 1'b0, 8'd0, 4'd1, 2'd0);
      stepc(4'd1, 1'b0, 8'd0, 4'd2, 2'd0);
      stepc(4'd2, 1'b0, 8'd0, 4'd3, 2'd0);
      stepc(4'd3, 1'b0, 8'd0, 4'd4, 2'd0);
      stepc(4'd4, 1'b1, 8'd0, 4'd5, 2'd0);
      for (int v = 5; v < 16; v++) stepc(4'(v), 1'b1, 8'd0, 4'(v + 1), 2'd0);
      for (int v = 0; v < 7; v++)  stepc(4'(v), 1'b1, 8'd0, 4'(v + 1), 2'd0);

      // Complement fault while locked (q=7 is in sequence).
      step(1'b1, 1'b1, 4'd7, 4'd0, 1'b0, 1'b1, 1'b0, 8'd1, 4'd8, 2'd1);
      stepc(4'd8,  1'b0, 8'd1, 4'd9,  2'd1);
      stepc(4'd9,  1'b0, 8'd1, 4'd10, 2'd1);
      stepc(4'd10, 1'b0, 8'd1, 4'd11, 2'd1);
      stepc(4'd11, 1'b0, 8'd1, 4'd12, 2'd1);
      stepc(4'd12, 1'b1, 8'd1, 4'd13, 2'd1);

      // Skipped count: ...5,6,8 then relock on 9..12.
      for (int v = 13; v < 16; v++) stepc(4'(v), 1'b1, 8'd1, 4'(v + 1), 2'd1);
      for (int v = 0; v < 7; v++)   stepc(4'(v), 1'b1, 8'd1, 4'(v + 1), 2'd1);
      step(1'b1, 1'b1, 4'd8, 4'd7, 1'b0, 1'b0, 1'b1, 8'd2, 4'd9, 2'd2);
      stepc(4'd9,  1'b0, 8'd2, 4'd10, 2'd2);
      stepc(4'd10, 1'b0, 8'd2, 4'd11, 2'd2);
      stepc(4'd11, 1'b0, 8'd2, 4'd12, 2'd2);
      stepc(4'd12, 1'b1, 8'd2, 4'd13, 2'd2);

      // Double fault with expected=3: both flags, single count.
      for (int v = 13; v < 16; v++) stepc(4'(v), 1'b1, 8'd2, 4'(v + 1), 2'd2);
      for (int v = 0; v < 3; v++)   stepc(4'(v), 1'b1, 8'd2, 4'(v + 1), 2'd2);
      step(1'b1, 1'b1, 4'd9, 4'd9, 1'b0, 1'b1, 1'b1, 8'd3, 4'd10, 2'd3);

      // Relock from IDLE, then en=0 with erratic inputs: everything holds.
      stepc(4'd0, 1'b0, 8'd3, 4'd1, 2'd3);
      stepc(4'd1, 1'b0, 8'd3, 4'd2, 2'd3);
      stepc(4'd2, 1'b0, 8'd3, 4'd3, 2'd3);
      stepc(4'd3, 1'b0, 8'd3, 4'd4, 2'd3);
      stepc(4'd4, 1'b1, 8'd3, 4'd5, 2'd3);
      step(1'b1, 1'b0, 4'd11, 4'd0,  1'b1, 1'b0, 1'b0, 8'd3, 4'd5, 2'd3);
      step(1'b1, 1'b0, 4'd2,  4'd2,  1'b1, 1'b0, 1'b0, 8'd3, 4'd5, 2'd3);
      step(1'b1, 1'b0, 4'd14, 4'd1,  1'b1, 1'b0, 1'b0, 8'd3, 4'd5, 2'd3);
      stepc(4'd5, 1'b1, 8'd3, 4'd6, 2'd3);

      // Reset for one edge while locked.
      step(1'b0, 1'b1, 4'd6, 4'd9, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 2'd0);

      // Saturation: five counted complement faults from SEEK.
      stepc(4'd0, 1'b0, 8'd0, 4'd1, 2'd0);
      step(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 8'd1, 4'd1, 2'd1);
      stepc(4'd0, 1'b0, 8'd1, 4'd1, 2'd1);
      step(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 8'd2, 4'd1, 2'd2);
      stepc(4'd0, 1'b0, 8'd2, 4'd1, 2'd2);
      step(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 8'd3, 4'd1, 2'd3);
      stepc(4'd0, 1'b0, 8'd3, 4'd1, 2'd3);
      step(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 8'd4, 4'd1, 2'd3);
      stepc(4'd0, 1'b0, 8'd4, 4'd1, 2'd3);
      step(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 8'd5, 4'd1, 2'd3);
      // Fault while in IDLE: flagged but not counted.
      step(1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b1, 1'b0, 8'd5, 4'd1, 2'd3);
      stepc(4'd0, 1'b0, 8'd5, 4'd1, 2'd3);

      // Drain the scoreboard with a bounded wait.
      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      @(posedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_dff_count_checker
